// File: rtl/dump_pkg.sv
// Shared types and constants for the architectural state dump controller.
package dump_pkg;

    localparam int unsigned IDX_W  = 9;
    localparam int unsigned SEL_W  = 5;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 10;

    // Last register index in the register phase.
    localparam logic [IDX_W-1:0] REG_LAST = 9'd31;

    // Value of the tag phase bit for memory words (register words use 0).
    localparam logic TAG_MEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REG_ADDR,
        ST_REG_CAP,
        ST_MEM_ADDR,
        ST_MEM_CAP,
        ST_EMIT,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        MODE_REG  = 2'b00,
        MODE_MEM  = 2'b01,
        MODE_BOTH = 2'b10
    } mode_t;

    // Dumped word tag: phase bit above the 9-bit index.
    typedef struct packed {
        logic             is_mem;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/state_dump_ctrl.sv
// Walks the register file and/or data memory and streams each word out
// over a valid/ready port tagged with its phase and index.
module state_dump_ctrl
    import dump_pkg::*;
#(
    parameter logic [8:0] MEM_LAST = 9'd63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [SEL_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_data
);

    state_t             state, state_nx;
    mode_t              mode_q, mode_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [SEL_W-1:0]   sel_nx;
    logic [ADDR_W-1:0]  addr_nx;
    tag_t               tag_q, tag_nx;
    logic [DATA_W-1:0]  data_nx;

    assign out_tag = tag_q;

    // Next-state, index and output-register values.
    always_comb begin
        state_nx = state;
        mode_nx  = mode_q;
        idx_nx   = idx;
        sel_nx   = reg_sel;
        addr_nx  = mem_addr;
        tag_nx   = tag_q;
        data_nx  = out_data;

        if (state != ST_IDLE && abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        idx_nx = '0;
                        if (mode == 2'(MODE_MEM)) begin
                            mode_nx  = MODE_MEM;
                            addr_nx  = '0;
                            state_nx = ST_MEM_ADDR;
                        end else begin
                            mode_nx  = (mode == 2'(MODE_REG)) ? MODE_REG : MODE_BOTH;
                            sel_nx   = '0;
                            state_nx = ST_REG_ADDR;
                        end
                    end
                end
                ST_REG_ADDR: state_nx = ST_REG_CAP;
                ST_REG_CAP: begin
                    data_nx  = reg_data;
                    tag_nx   = '{is_mem: ~TAG_MEM, idx: idx};
                    state_nx = ST_EMIT;
                end
                ST_MEM_ADDR: state_nx = ST_MEM_CAP;
                ST_MEM_CAP: begin
                    data_nx  = mem_data;
                    tag_nx   = '{is_mem: TAG_MEM, idx: idx};
                    state_nx = ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (tag_q.is_mem != TAG_MEM) begin
                            if (idx == REG_LAST) begin
                                if (mode_q == MODE_BOTH) begin
                                    idx_nx   = '0;
                                    addr_nx  = '0;
                                    state_nx = ST_MEM_ADDR;
                                end else begin
                                    state_nx = ST_FINISH;
                                end
                            end else begin
                                idx_nx   = idx + 9'd1;
                                sel_nx   = SEL_W'(idx + 9'd1);
                                state_nx = ST_REG_ADDR;
                            end
                        end else begin
                            if (idx == MEM_LAST) begin
                                state_nx = ST_FINISH;
                            end else begin
                                idx_nx   = idx + 9'd1;
                                addr_nx  = ADDR_W'(idx + 9'd1);
                                state_nx = ST_MEM_ADDR;
                            end
                        end
                    end
                end
                ST_FINISH: state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    // State, counter and registered outputs; status flags track the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_REG;
            idx       <= '0;
            reg_sel   <= '0;
            mem_addr  <= '0;
            tag_q     <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            mode_q    <= mode_nx;
            idx       <= idx_nx;
            reg_sel   <= sel_nx;
            mem_addr  <= addr_nx;
            tag_q     <= tag_nx;
            out_data  <= data_nx;
            busy      <= (state_nx != ST_IDLE);
            done      <= (state_nx == ST_FINISH);
            out_valid <= (state_nx == ST_EMIT);
        end
    end

endmodule

// File: tb/tb_state_dump_ctrl.sv
// Bench for state_dump_ctrl: cycle vectors, directed dumps and random dumps
// scored against an expected word list built from the dump rules.
module tb_state_dump_ctrl;

    localparam logic [8:0] MEM_LAST_TB = 9'd3;

    logic        clk = 1'b0;
    logic        reset, start, abort, out_ready;
    logic [1:0]  mode;
    logic        busy, done, out_valid;
    logic [4:0]  reg_sel;
    logic [8:0]  mem_addr;
    logic [31:0] reg_data, mem_data, out_data;
    logic [9:0]  out_tag;

    logic [31:0] regs [32];
    logic [31:0] mem  [512];

    // Combinational datapath read ports.
    assign reg_data = regs[reg_sel];
    assign mem_data = mem[mem_addr];

    state_dump_ctrl #(.MEM_LAST(MEM_LAST_TB)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .busy(busy), .done(done), .reg_sel(reg_sel), .reg_data(reg_data),
        .mem_addr(mem_addr), .mem_data(mem_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [9:0]  tag;
        logic [31:0] data;
    } word_t;
    word_t exp_q[$];

    typedef struct {
        logic        rst, st;
        logic [1:0]  md;
        logic        ab, rdy;
        logic        e_busy, e_done, e_valid;
        logic [9:0]  e_tag;
        logic [31:0] e_data;
    } vec_t;
    vec_t vt[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected word list straight from the mode rules.
    task automatic build_model(input logic [1:0] m);
        exp_q.delete();
        if (m != 2'b01)
            for (int i = 0; i < 32; i++) exp_q.push_back({1'b0, 9'(i), regs[i]});
        if (m != 2'b00)
            for (int i = 0; i <= int'(MEM_LAST_TB); i++) exp_q.push_back({1'b1, 9'(i), mem[i]});
    endtask

    // One complete dump, scoreboarded, with handshake stability and done timing checks.
    task automatic run_dump(input logic [1:0] m, input bit rnd_ready, input int stall_word,
                            input int stall_len, input bit rnd_start);
        int cyc, words, stall_cnt, low_cnt, done_cnt, done_cyc, nwords;
        bit prev_valid, prev_ready, rdy;
        logic [9:0] prev_tag;
        logic [31:0] prev_data;
        word_t w;
        build_model(m);
        nwords = exp_q.size();
        start = 1'b1; mode = m; abort = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
        cyc = 1; words = 0; stall_cnt = 0; low_cnt = 0; done_cnt = 0; done_cyc = -1;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_tag = '0; prev_data = '0;
        while (cyc < 2000 && done_cnt == 0) begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_tag", 32'(out_tag), 32'(prev_tag));
                check("hold_data", out_data, prev_data);
            end
            check("busy_during_dump", 32'(busy), 32'd1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end else begin
                rdy = 1'b1;
                if (rnd_ready) rdy = ($urandom_range(0, 3) != 0);
                if (out_valid && words == stall_word && stall_cnt < stall_len) begin
                    rdy = 1'b0;
                    stall_cnt++;
                end
                if (out_valid && !rdy) low_cnt++;
                out_ready = rdy;
                start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
                mode  = rnd_start ? 2'($urandom_range(0, 3)) : m;
                if (out_valid && rdy) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 32'(out_tag), 32'hFFFF_FFFF);
                    end else begin
                        w = exp_q.pop_front();
                        check("word_tag", 32'(out_tag), 32'(w.tag));
                        check("word_data", out_data, w.data);
                    end
                    words++;
                end
                prev_valid = out_valid; prev_ready = rdy;
                prev_tag = out_tag; prev_data = out_data;
                step();
                cyc++;
            end
        end
        check("done_seen", 32'(done_cnt), 32'd1);
        check("words_left", 32'(exp_q.size()), 32'd0);
        check("done_cycle", 32'(done_cyc), 32'(nwords * 3 + 1 + low_cnt));
        start = 1'b0; out_ready = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);
        check("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 16);
        for (int i = 0; i < 512; i++) mem[i] = 32'(32'hA0 + i);
        reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00; out_ready = 1'b0;

        // rst st md ab rdy | busy done valid tag data
        vt[0]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 32'h00};
        vt[1]  = '{1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 32'h00};
        vt[2]  = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 32'h00};
        vt[3]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 32'h00};
        vt[4]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h000, 32'h00};
        vt[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h000, 32'h00};
        vt[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 32'h00};
        vt[7]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 32'h00};
        vt[8]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h001, 32'h10};
        vt[9]  = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 32'h00};
        vt[10] = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 32'h00};
        vt[11] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 32'h00};
        vt[12] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h200, 32'hA0};
        vt[13] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 32'h00};
        vt[14] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 32'h00};
        vt[15] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h201, 32'hA1};
        vt[16] = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 32'h00};

        for (int i = 0; i < 17; i++) begin
            reset = vt[i].rst; start = vt[i].st; mode = vt[i].md;
            abort = vt[i].ab; out_ready = vt[i].rdy;
            step();
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].e_done));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].e_valid));
            if (vt[i].e_valid || !vt[i].rst) begin
                check($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(vt[i].e_tag));
                check($sformatf("vec%0d_data", i), out_data, vt[i].e_data);
            end
            if (!vt[i].rst) begin
                check("reset_reg_sel", 32'(reg_sel), 32'd0);
                check("reset_mem_addr", 32'(mem_addr), 32'd0);
            end
        end
        start = 1'b0; abort = 1'b0;
        step();

        // Registers only, ready tied high: 32 words, done on cycle 97.
        run_dump(2'b00, 1'b0, -1, 0, 1'b0);
        // Memory only: four words 0xA0..0xA3.
        run_dump(2'b01, 1'b0, -1, 0, 1'b0);
        // Both phases with a 5-cycle stall on word 2.
        run_dump(2'b10, 1'b0, 2, 5, 1'b0);
        // Mode 11 behaves as 10.
        run_dump(2'b11, 1'b0, -1, 0, 1'b0);

        // Abort while register 7 is being offered.
        start = 1'b1; mode = 2'b00; out_ready = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (out_valid && out_tag == 10'd7) found = 1'b1;
            else step();
        end
        check("abort_reached_idx7", 32'(found), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("abort_no_done", 32'(done | busy), 32'd0);
        end
        run_dump(2'b00, 1'b0, -1, 0, 1'b0);

        // Random data, ready and start-while-busy.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
            for (int i = 0; i < 8; i++) mem[i] = $urandom;
            run_dump(2'($urandom_range(0, 3)), 1'b1, -1, 0, 1'b1);
        end

        // Reset while in MEM_CAP.
        start = 1'b1; mode = 2'b01; out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_reg_sel", 32'(reg_sel), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        check("rst_data", out_data, 32'd0);
        reset = 1'b1;
        step();
        check("post_rst_idle", 32'(busy | out_valid | done), 32'd0);
        run_dump(2'b01, 1'b0, -1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
